clkdiv_mode_ctrl: RTL and testbench

Sequencing controller for the 2-bit-controlled clock divider `dived2f`. It owns the divider's `control` and `reset` inputs and accepts mode-change requests from software or test logic. It can also step the divider through all four ratios automatically. Every ratio change is applied only at a clean output boundary, with a one-cycle divider reset and lock confirmation, so downstream logic never sees a runt pulse of undefined length.

---
 rtl/clkdiv_mode_ctrl.sv | 156 +++++++++++++++
 tb/tb_clkdiv_mode_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_mode_ctrl.sv
// clkdiv_mode_ctrl
//   Sequencing controller for the 2-bit-controlled clock divider. Owns the
//   divider's ratio select and synchronous reset, accepts mode-change
//   requests and can step through all four ratios automatically. A ratio
//   change always waits for a falling edge of the divider output, then
//   applies the new ratio with a one-cycle divider reset and waits for the
//   first rising edge to confirm lock.
//
// Parameters
//   DWELL_W      width of the auto-mode dwell count
//   TMO          cycles allowed for an expected div_q edge
// Ports
//   clk_i        system clock, rising edge
//   reset_i      synchronous, active-high reset
//   req_i        mode-change request, sampled only while ready_o=1
//   sel_in_i     requested mode, sampled with req_i
//   auto_en_i    enable automatic mode stepping while running
//   dwell_i      div_q rising edges per mode in auto (0 behaves as 1)
//   div_q_i      divider output
//   control_o    divider ratio select (registered)
//   div_reset_o  divider synchronous reset (registered)
//   ready_o      high only while running in a locked mode
//   done_o       one-cycle pulse when a mode locks / same-mode request
//   mode_o       last locked mode
//   err_o        sticky lock-failure flag, cleared only by reset_i
module clkdiv_mode_ctrl #(
  parameter int DWELL_W = 8,
  parameter int TMO     = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req_i,
  input  logic [1:0]         sel_in_i,
  input  logic               auto_en_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               div_q_i,
  output logic [1:0]         control_o,
  output logic               div_reset_o,
  output logic               ready_o,
  output logic               done_o,
  output logic [1:0]         mode_o,
  output logic               err_o
);

  localparam int TW = (TMO > 2) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TMO - 1);

  typedef enum logic [1:0] {APPLY, SETTLE, RUN, WAIT_EDGE} state_e;

  state_e             st_q;
  logic [1:0]         pending_q;
  logic [1:0]         control_q;
  logic [1:0]         mode_q;
  logic               div_reset_q;
  logic               ready_q;
  logic               done_q;
  logic               err_q;
  logic               q_prev_q;
  logic [DWELL_W-1:0] ecnt_q;
  logic [TW-1:0]      tcnt_q;

  logic               rise;
  logic               fall;
  logic               tmo_hit;
  logic [DWELL_W:0]   ecnt_d;
  logic               dwell_hit;

  assign rise    = div_q_i & ~q_prev_q;
  assign fall    = ~div_q_i & q_prev_q;
  assign tmo_hit = (tcnt_q == TLAST);
  assign ecnt_d  = {1'b0, ecnt_q} + 1'b1;
  // ecnt_d is at least 1, so a dwell of 0 naturally behaves as 1.
  assign dwell_hit = (ecnt_d >= {1'b0, dwell_i});

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q        <= APPLY;
      pending_q   <= 2'd0;
      control_q   <= 2'd0;
      mode_q      <= 2'd0;
      div_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      q_prev_q    <= 1'b0;
      ecnt_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      q_prev_q <= div_q_i;
      done_q   <= 1'b0;
      unique case (st_q)
        APPLY: begin
          div_reset_q <= 1'b0;
          tcnt_q      <= '0;
          st_q        <= SETTLE;
        end
        SETTLE: begin
          if (rise) begin
            st_q    <= RUN;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            mode_q  <= pending_q;
            ecnt_q  <= '0;
          end else if (tmo_hit) begin
            // Divider never came up: flag it and retry the same ratio.
            err_q       <= 1'b1;
            st_q        <= APPLY;
            div_reset_q <= 1'b1;
            control_q   <= pending_q;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        RUN: begin
          if (req_i) begin
            if (sel_in_i != mode_q) begin
              pending_q <= sel_in_i;
              st_q      <= WAIT_EDGE;
              ready_q   <= 1'b0;
              tcnt_q    <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end else if (auto_en_i && rise) begin
            if (dwell_hit) begin
              pending_q <= mode_q + 2'd1;
              st_q      <= WAIT_EDGE;
              ready_q   <= 1'b0;
              tcnt_q    <= '0;
            end else begin
              ecnt_q <= ecnt_d[DWELL_W-1:0];
            end
          end
        end
        WAIT_EDGE: begin
          // Let the current high phase finish before resetting the divider.
          if (fall || tmo_hit) begin
            st_q        <= APPLY;
            div_reset_q <= 1'b1;
            control_q   <= pending_q;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign control_o   = control_q;
  assign div_reset_o = div_reset_q;
  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign mode_o      = mode_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_clkdiv_mode_ctrl.sv
// Bench for clkdiv_mode_ctrl: a divider model closes the loop, every cycle's
// outputs are logged, and each scenario predicts event cycles arithmetically.
module tb_clkdiv_mode_ctrl;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, req = 1'b0, auto_en = 1'b0, tie0 = 1'b0;
  logic [1:0] sel_in = 2'd0;
  logic [7:0] dwell = 8'd0;
  logic       div_q, div_reset, ready, done, err;
  logic [1:0] control, mode;

  // Divider: mode n divides by 2^(n+1); output is bit n of a free counter.
  logic [3:0] dc = 4'd0;
  logic       dq = 1'b0;
  always @(posedge clk)
    if (div_reset) begin dc <= 4'd0; dq <= 1'b0; end
    else begin dc <= dc + 4'd1; dq <= |(((dc + 4'd1) >> control) & 4'd1); end
  assign div_q = tie0 ? 1'b0 : dq;

  clkdiv_mode_ctrl #(.DWELL_W(8), .TMO(32)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .sel_in_i(sel_in),
    .auto_en_i(auto_en), .dwell_i(dwell), .div_q_i(div_q),
    .control_o(control), .div_reset_o(div_reset), .ready_o(ready),
    .done_o(done), .mode_o(mode), .err_o(err));

  // cyc = number of rising edges so far; logs are indexed by it.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       lq[MAXC], ldr[MAXC], ldone[MAXC], lrdy[MAXC], lerr[MAXC];
  logic [1:0] lctl[MAXC], lmode[MAXC];
  always @(negedge clk)
    if (cyc < MAXC) begin
      lq[cyc] <= div_q;   ldr[cyc] <= div_reset; ldone[cyc] <= done;
      lrdy[cyc] <= ready; lerr[cyc] <= err;      lctl[cyc] <= control;
      lmode[cyc] <= mode;
    end

  int errors = 0, checks = 0;
  logic [1:0] exp_mode = 2'd0;

  task automatic nclk(); @(negedge clk); #1; endtask
  task automatic run(input int n); repeat (n) nclk(); endtask

  task automatic do_reset(output int r);
    reset = 1'b1; run(3); r = cyc; reset = 1'b0;
  endtask

  task automatic goto_mode(input logic [1:0] m);
    int n;
    req = 1'b1; sel_in = m; nclk(); req = 1'b0;
    n = 0;
    while (n < 60 && ldone[cyc] !== 1'b1) begin nclk(); n++; end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL goto_mode: no done within 60 cycles for mode %0d", m); end
    exp_mode = m; run(2);
  endtask

  task automatic test_reset();
    int r;
    reset = 1'b1; req = 1'b0; auto_en = 1'b0; tie0 = 1'b0; run(3);
    checks++;
    if ({control, div_reset, ready, done, mode, err} !== 8'b00_1_0_0_00_0) begin
      errors++; $display("FAIL reset_vals: got ctl=%0d dr=%0b rdy=%0b done=%0b mode=%0d err=%0b, want 0 1 0 0 0 0",
                         control, div_reset, ready, done, mode, err);
    end
    r = cyc; reset = 1'b0; run(8);
    checks++;
    if (ldr[r] !== 1'b1 || ldr[r+1] !== 1'b0) begin
      errors++; $display("FAIL reset_apply: dr at release=%0b next=%0b, want 1 0", ldr[r], ldr[r+1]);
    end
    checks++;
    if (ldone[r+2] !== 1'b0 || ldone[r+3] !== 1'b1 || lmode[r+3] !== 2'd0 || lrdy[r+3] !== 1'b1 || lerr[r+3] !== 1'b0) begin
      errors++; $display("FAIL reset_lock: done=%0b%0b mode=%0d rdy=%0b err=%0b, want done 01 mode 0 rdy 1 err 0",
                         ldone[r+2], ldone[r+3], lmode[r+3], lrdy[r+3], lerr[r+3]);
    end
    exp_mode = 2'd0;
  endtask

  task automatic test_req_change();
    logic [1:0] sel;
    int k, f, d, nd, ndr;
    for (int it = 0; it < 6; it++) begin
      sel = (it == 0) ? 2'd2 : exp_mode + 2'($urandom_range(1, 3));
      run($urandom_range(0, 7));
      req = 1'b1; sel_in = sel; k = cyc + 1; nclk();
      // A second request while not ready must be ignored.
      if (it % 2 == 1) begin sel_in = sel ^ 2'd1; nclk(); end
      req = 1'b0; sel_in = 2'($urandom); run(44);
      f = 0;
      for (int e = k + 1; e <= k + 30; e++)
        if (f == 0 && lq[e-1] === 1'b0 && lq[e-2] === 1'b1) f = e;
      checks++;
      if (f == 0) begin
        errors++; $display("FAIL req_fall_found: no div_q falling edge after req at cycle %0d", k);
      end else begin
        d = f + 2 + (1 << sel);
        checks++;
        if ({ldr[f-1], ldr[f], ldr[f+1]} !== 3'b010 || lctl[f] !== sel) begin
          errors++; $display("FAIL req_apply it%0d: dr=%b ctl=%0d, want 010 ctl=%0d",
                             it, {ldr[f-1], ldr[f], ldr[f+1]}, lctl[f], sel);
        end
        checks++;
        if (lrdy[k] !== 1'b0 || lrdy[d-1] !== 1'b0) begin
          errors++; $display("FAIL req_ready_low it%0d: rdy=%0b,%0b want 0,0", it, lrdy[k], lrdy[d-1]);
        end
        nd = 0;
        for (int c = k; c < d; c++) if (ldone[c] === 1'b1) nd++;
        checks++;
        if (ldone[d] !== 1'b1 || nd != 0 || lmode[d] !== sel || lrdy[d] !== 1'b1) begin
          errors++; $display("FAIL req_lock it%0d: done=%0b early=%0d mode=%0d rdy=%0b, want 1 0 %0d 1",
                             it, ldone[d], nd, lmode[d], lrdy[d], sel);
        end
        ndr = 0;
        for (int c = f + 1; c <= k + 44; c++) if (ldr[c] === 1'b1) ndr++;
        checks++;
        if (ndr != 0) begin errors++; $display("FAIL req_single_apply it%0d: %0d extra div_reset cycles, want 0", it, ndr); end
        if (it == 0) begin
          checks++;
          if ({lq[d-2], lq[d-1], lq[d+2], lq[d+3], lq[d+6], lq[d+7]} !== 6'b011001) begin
            errors++; $display("FAIL div_period8: q samples=%b want 011001",
                               {lq[d-2], lq[d-1], lq[d+2], lq[d+3], lq[d+6], lq[d+7]});
          end
        end
      end
      exp_mode = sel;
    end
  endtask

  task automatic test_same_mode();
    int k, ndr, nbad;
    if (exp_mode != 2'd1) goto_mode(2'd1);
    run($urandom_range(0, 5));
    req = 1'b1; sel_in = 2'd1; k = cyc + 1; nclk(); req = 1'b0; run(20);
    checks++;
    if ({ldone[k-1], ldone[k], ldone[k+1]} !== 3'b010 || lmode[k] !== 2'd1) begin
      errors++; $display("FAIL same_done: done=%b mode=%0d, want 010 mode 1", {ldone[k-1], ldone[k], ldone[k+1]}, lmode[k]);
    end
    ndr = 0;
    for (int c = k - 2; c <= k + 20; c++) if (ldr[c] === 1'b1) ndr++;
    checks++;
    if (ndr != 0) begin errors++; $display("FAIL same_no_reset: %0d div_reset cycles, want 0", ndr); end
    nbad = 0;
    for (int e = k - 2; e <= k + 18; e++) if (lq[e] !== lq[e-4]) nbad++;
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL same_phase: %0d phase breaks, want 0", nbad); end
    checks++;
    if (lrdy[k] !== 1'b1 || lrdy[k+1] !== 1'b1) begin
      errors++; $display("FAIL same_ready: rdy=%0b%0b want 11", lrdy[k], lrdy[k+1]);
    end
  endtask

  task automatic test_auto(input int dw);
    int r, n, nn, D, P, nd;
    int L[5];
    auto_en = 1'b1; dwell = 8'(dw); do_reset(r);
    D = (dw == 0) ? 1 : dw;
    // Lock edge, D full periods, half period to the fall, apply, settle.
    L[0] = r + 3; n = 0;
    for (int i = 0; i < 4; i++) begin
      P = 2 << n; nn = (n + 1) % 4;
      L[i+1] = L[i] + D * P + P / 2 + 2 + (1 << nn);
      n = nn;
    end
    run(L[4] - cyc + 2);
    auto_en = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ldone[L[i]] !== 1'b1 || lmode[L[i]] !== 2'(n)) begin
        errors++; $display("FAIL auto_lock dwell=%0d step%0d: done=%0b mode=%0d at %0d, want 1 mode %0d",
                           dw, i, ldone[L[i]], lmode[L[i]], L[i], n);
      end
      if (i < 4) begin
        nn = (n + 1) % 4;
        checks++;
        if (ldr[L[i+1]-2-(1<<nn)] !== 1'b1 || lctl[L[i+1]-2-(1<<nn)] !== 2'(nn)) begin
          errors++; $display("FAIL auto_apply dwell=%0d step%0d: dr=%0b ctl=%0d, want 1 ctl %0d",
                             dw, i, ldr[L[i+1]-2-(1<<nn)], lctl[L[i+1]-2-(1<<nn)], nn);
        end
      end
      n = (n + 1) % 4;
    end
    nd = 0;
    for (int c = L[0]; c <= L[4]; c++) if (ldone[c] === 1'b1) nd++;
    checks++;
    if (nd != 5) begin errors++; $display("FAIL auto_done_count dwell=%0d: %0d pulses, want 5", dw, nd); end
  endtask

  task automatic test_timeout();
    int r, ndr, nrdy;
    tie0 = 1'b1; do_reset(r); run(75);
    checks++;
    if (ldr[r] !== 1'b1 || ldr[r+33] !== 1'b1 || ldr[r+66] !== 1'b1) begin
      errors++; $display("FAIL tmo_apply: dr at +0/+33/+66 = %0b%0b%0b, want 111", ldr[r], ldr[r+33], ldr[r+66]);
    end
    ndr = 0;
    for (int c = r + 1; c <= r + 65; c++) if (c != r + 33 && ldr[c] === 1'b1) ndr++;
    checks++;
    if (ndr != 0) begin errors++; $display("FAIL tmo_apply_gap: %0d extra div_reset cycles, want 0", ndr); end
    checks++;
    if (lerr[r+32] !== 1'b0 || lerr[r+33] !== 1'b1 || lerr[r+75] !== 1'b1) begin
      errors++; $display("FAIL tmo_err: err at +32/+33/+75 = %0b%0b%0b, want 011", lerr[r+32], lerr[r+33], lerr[r+75]);
    end
    nrdy = 0;
    for (int c = r; c <= r + 75; c++) if (lrdy[c] === 1'b1) nrdy++;
    checks++;
    if (nrdy != 0) begin errors++; $display("FAIL tmo_ready: ready high %0d cycles, want 0", nrdy); end
    tie0 = 1'b0; run(40);
    checks++;
    if (err !== 1'b1 || ready !== 1'b1 || mode !== 2'd0) begin
      errors++; $display("FAIL tmo_err_sticky: err=%0b rdy=%0b mode=%0d, want 1 1 0", err, ready, mode);
    end
    exp_mode = 2'd0;
  endtask

  task automatic test_reset_mid();
    int L, n, n3;
    req = 1'b1; sel_in = 2'd2; nclk(); req = 1'b0;
    n = 0;
    while (n < 60 && ldone[cyc] !== 1'b1) begin nclk(); n++; end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL mid_lock2: no done within 60 cycles"); end
    L = cyc;
    req = 1'b1; sel_in = 2'd3; nclk(); req = 1'b0;
    reset = 1'b1;
    checks++;
    if (ready !== 1'b0 || control !== 2'd2) begin
      errors++; $display("FAIL mid_wait: rdy=%0b ctl=%0d, want 0 2", ready, control);
    end
    nclk(); reset = 1'b0;
    checks++;
    if ({control, div_reset, mode, err, ready, done} !== 8'b00_1_00_0_0_0) begin
      errors++; $display("FAIL mid_reset_vals: ctl=%0d dr=%0b mode=%0d err=%0b rdy=%0b done=%0b, want 0 1 0 0 0 0",
                         control, div_reset, mode, err, ready, done);
    end
    run(20);
    checks++;
    if (ldone[L+5] !== 1'b1 || lmode[L+5] !== 2'd0) begin
      errors++; $display("FAIL mid_relock: done=%0b mode=%0d, want 1 0", ldone[L+5], lmode[L+5]);
    end
    n3 = 0;
    for (int c = L + 1; c <= L + 22; c++) if (lctl[c] === 2'd3) n3++;
    checks++;
    if (n3 != 0) begin errors++; $display("FAIL mid_discard: control=3 for %0d cycles, want 0", n3); end
  endtask

  // Whole-run properties over the log.
  task automatic test_invariants();
    for (int c = 2; c < cyc && c < MAXC; c++) begin
      if (lctl[c] !== lctl[c-1]) begin
        checks++;
        if (ldr[c] !== 1'b1) begin
          errors++; $display("FAIL ctl_without_reset cycle %0d: dr=%0b, want 1", c, ldr[c]);
        end
      end
      if (ldone[c] === 1'b1) begin
        checks++;
        if (lrdy[c] !== 1'b1 || ldr[c] !== 1'b0 || ldone[c-1] === 1'b1) begin
          errors++; $display("FAIL done_qual cycle %0d: rdy=%0b dr=%0b prev_done=%0b, want 1 0 0",
                             c, lrdy[c], ldr[c], ldone[c-1]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_req_change();
    test_same_mode();
    test_auto(2);
    test_auto(0);
    test_auto($urandom_range(1, 4));
    test_timeout();
    test_reset_mid();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
